// File: rtl/sl_preceptron_packer.sv
// Purpose: packs DATA_LANES serial elements into one wide word, buffered in a FWFT word FIFO.
// Latency: a word committed at edge N is presented on data_out in cycle N+1.
// Backpressure: data_in_ready drops when the FIFO is full or the frame is flushing/done.
module sl_preceptron_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_LANES = 4,
  parameter int WORD_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             data_in_valid,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             data_in_last,
  output logic                             data_in_ready,
  output logic                             data_out_valid,
  output logic [DATA_WIDTH*DATA_LANES-1:0] data_out,
  output logic [DATA_LANES-1:0]            data_out_keep,
  output logic                             data_out_last,
  input  logic                             data_out_ready,
  output logic                             start_vector_packing,
  output logic                             done_vector_packing
);

  localparam int WW = DATA_WIDTH * DATA_LANES;
  localparam int AW = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
  localparam int LW = (DATA_LANES > 1) ? $clog2(DATA_LANES) : 1;
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(WORD_DEPTH);
  localparam logic [LW-1:0] LAST_LANE = LW'(DATA_LANES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PACK  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic [WW-1:0]         dat;
    logic [DATA_LANES-1:0] keep;
    logic                  last;
  } word_t;

  word_t         mem_q [WORD_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [1:0]    state_q, state_d;
  logic [WW-1:0] acc_q;
  logic [LW-1:0] lane_idx_q;
  logic [10:0]   rcv_elem_cnt_q, rcv_elem_cnt_d;
  logic [10:0]   send_word_cnt_q, send_word_cnt_d;
  logic          in_fire, commit, pop;
  word_t         head, word_d;

  // Handshakes and FWFT outputs; the head is gated so an empty FIFO shows all zeros.
  always_comb begin
    head                 = mem_q[rd_ptr_q];
    data_in_ready        = ~rst & (count_q < DEPTH_C) &
                           ((state_q == ST_IDLE) | (state_q == ST_PACK));
    in_fire              = data_in_valid & data_in_ready;
    commit               = in_fire & ((lane_idx_q == LAST_LANE) | data_in_last);
    data_out_valid       = ~rst & (count_q != '0);
    pop                  = data_out_valid & data_out_ready;
    data_out             = data_out_valid ? head.dat  : '0;
    data_out_keep        = data_out_valid ? head.keep : '0;
    data_out_last        = data_out_valid & head.last;
    start_vector_packing = in_fire & (state_q == ST_IDLE);
    done_vector_packing  = ~rst & (state_q == ST_DONE);
  end

  // Accumulator with the incoming element merged into its lane; keep covers lanes 0..lane_idx.
  always_comb begin
    word_d     = '0;
    word_d.dat = acc_q;
    for (int i = 0; i < DATA_LANES; i++) begin
      if (LW'(i) == lane_idx_q) word_d.dat[i*DATA_WIDTH +: DATA_WIDTH] = data_in;
      word_d.keep[i] = (LW'(i) <= lane_idx_q);
    end
    word_d.last = data_in_last;
  end

  // Frame FSM and per-frame element/word counters (counters restart from IDLE).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_fire) state_d = data_in_last ? ST_FLUSH : ST_PACK;
      ST_PACK:  if (in_fire && data_in_last) state_d = ST_FLUSH;
      ST_FLUSH: if (pop && head.last) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    rcv_elem_cnt_d  = (state_q == ST_IDLE) ? 11'(in_fire) : rcv_elem_cnt_q + 11'(in_fire);
    send_word_cnt_d = (state_q == ST_IDLE) ? 11'(pop)     : send_word_cnt_q + 11'(pop);
  end

  // Control state, FIFO pointers/occupancy and lane accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      acc_q           <= '0;
      lane_idx_q      <= '0;
      rcv_elem_cnt_q  <= '0;
      send_word_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      rcv_elem_cnt_q  <= rcv_elem_cnt_d;
      send_word_cnt_q <= send_word_cnt_d;
      if (commit) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({commit, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (commit) begin
        acc_q      <= '0;
        lane_idx_q <= '0;
      end else if (in_fire) begin
        acc_q      <= word_d.dat;
        lane_idx_q <= lane_idx_q + 1'b1;
      end
    end
  end

  // Word storage; contents need no reset because reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (commit) mem_q[wr_ptr_q] <= word_d;
  end

  // Every element accepted in a frame must leave in exactly ceil(n/lanes) popped words.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_DONE)
      assert (send_word_cnt_q == 11'((32'(rcv_elem_cnt_q) + DATA_LANES - 1) / DATA_LANES));
  end

endmodule

// File: tb/tb_sl_preceptron_packer.sv
// Directed bench for sl_preceptron_packer with 8-bit elements, 4 lanes, 4-word FIFO.
module tb_sl_preceptron_packer;
  logic        clk = 1'b0;
  logic        rst;
  logic        data_in_valid;
  logic [7:0]  data_in;
  logic        data_in_last;
  logic        data_in_ready;
  logic        data_out_valid;
  logic [31:0] data_out;
  logic [3:0]  data_out_keep;
  logic        data_out_last;
  logic        data_out_ready;
  logic        start_vector_packing;
  logic        done_vector_packing;

  int passed = 0;
  int total  = 0;

  sl_preceptron_packer #(.DATA_WIDTH(8), .DATA_LANES(4), .WORD_DEPTH(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .data_in_valid        (data_in_valid),
    .data_in              (data_in),
    .data_in_last         (data_in_last),
    .data_in_ready        (data_in_ready),
    .data_out_valid       (data_out_valid),
    .data_out             (data_out),
    .data_out_keep        (data_out_keep),
    .data_out_last        (data_out_last),
    .data_out_ready       (data_out_ready),
    .start_vector_packing (start_vector_packing),
    .done_vector_packing  (done_vector_packing)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [32:0] words[$];
  int          pops[$];
  int          nacc;
  bit          got_done;
  bit          rdy_drop;
  logic        flush_rdy;
  int          maxcnt;

  initial begin
    rst = 1'b1; data_in_valid = 1'b0; data_in = '0; data_in_last = 1'b0; data_out_ready = 1'b1;
    tick(); tick(); tick();
    #1;
    check("rst_in_ready", {31'd0, data_in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, data_out_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, data_in_ready}, 32'd1);
    check("post_rst_data_out", data_out, 32'd0);
    check("post_rst_keep", {28'd0, data_out_keep}, 32'd0);
    check("post_rst_done", {31'd0, done_vector_packing}, 32'd0);
    tick();

    // 1: eight bytes, two full words
    for (int k = 1; k <= 8; k++) begin
      data_in_valid = 1'b1; data_in = 8'(k); data_in_last = (k == 8);
      #1;
      if (k == 1) check("t1_start", {31'd0, start_vector_packing}, 32'd1);
      if (k == 2) check("t1_start_once", {31'd0, start_vector_packing}, 32'd0);
      if (k == 5) begin
        check("t1_w0_valid", {31'd0, data_out_valid}, 32'd1);
        check("t1_w0_data", data_out, 32'h04030201);
        check("t1_w0_keep", {28'd0, data_out_keep}, 32'hF);
        check("t1_w0_last", {31'd0, data_out_last}, 32'd0);
      end
      tick();
    end
    data_in_valid = 1'b0; data_in_last = 1'b0;
    #1;
    check("t1_w1_data", data_out, 32'h08070605);
    check("t1_w1_keep", {28'd0, data_out_keep}, 32'hF);
    check("t1_w1_last", {31'd0, data_out_last}, 32'd1);
    check("t1_flush_in_ready", {31'd0, data_in_ready}, 32'd0);
    check("t1_done_early", {31'd0, done_vector_packing}, 32'd0);
    tick();
    check("t1_done", {31'd0, done_vector_packing}, 32'd1);
    check("t1_done_valid", {31'd0, data_out_valid}, 32'd0);
    tick();
    check("t1_done_clear", {31'd0, done_vector_packing}, 32'd0);
    check("t1_idle_ready", {31'd0, data_in_ready}, 32'd1);

    // 2: six bytes, partial final word
    for (int k = 1; k <= 6; k++) begin
      data_in_valid = 1'b1; data_in = 8'(k); data_in_last = (k == 6);
      #1;
      if (k == 5) check("t2_w0_data", data_out, 32'h04030201);
      tick();
    end
    data_in_valid = 1'b0; data_in_last = 1'b0;
    #1;
    check("t2_w1_data", data_out, 32'h00000605);
    check("t2_w1_keep", {28'd0, data_out_keep}, 32'h3);
    check("t2_w1_last", {31'd0, data_out_last}, 32'd1);
    tick();
    check("t2_done", {31'd0, done_vector_packing}, 32'd1);
    tick();

    // 3: consumer stalled, FIFO fills, then drains in order
    data_out_ready = 1'b0; nacc = 0;
    for (int c = 0; c < 40 && nacc < 16; c++) begin
      data_in_valid = 1'b1; data_in = 8'(nacc + 1); data_in_last = 1'b0;
      #1;
      if (data_in_ready) nacc++;
      tick();
    end
    #1;
    check("t3_accepted", 32'(nacc), 32'd16);
    check("t3_full_in_ready", {31'd0, data_in_ready}, 32'd0);
    tick();
    check("t3_hold_in_ready", {31'd0, data_in_ready}, 32'd0);
    check("t3_hold_data", data_out, 32'h04030201);
    data_out_ready = 1'b1; got_done = 1'b0;
    for (int c = 0; c < 60 && !got_done; c++) begin
      data_in_valid = (nacc < 20); data_in = 8'(nacc + 1); data_in_last = (nacc == 19);
      #1;
      if (data_in_valid && data_in_ready) nacc++;
      if (data_out_valid) words.push_back({data_out_last, data_out});
      tick();
      if (done_vector_packing) got_done = 1'b1;
    end
    data_in_valid = 1'b0; data_in_last = 1'b0;
    check("t3_done", {31'd0, got_done}, 32'd1);
    check("t3_word_count", 32'(words.size()), 32'd5);
    for (int i = 0; i < 5 && i < words.size(); i++) begin
      check("t3_word_data", words[i][31:0],
            {8'(4*i + 4), 8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1)});
      check("t3_word_last", {31'd0, words[i][32]}, (i == 4) ? 32'd1 : 32'd0);
    end
    tick();

    // 4: single-element frame
    data_in_valid = 1'b1; data_in = 8'hAA; data_in_last = 1'b1;
    #1;
    check("t4_start", {31'd0, start_vector_packing}, 32'd1);
    tick();
    data_in_valid = 1'b0; data_in_last = 1'b0;
    #1;
    check("t4_data", data_out, 32'h000000AA);
    check("t4_keep", {28'd0, data_out_keep}, 32'h1);
    check("t4_last", {31'd0, data_out_last}, 32'd1);
    check("t4_in_ready", {31'd0, data_in_ready}, 32'd0);
    tick();
    check("t4_done", {31'd0, done_vector_packing}, 32'd1);
    tick();

    // 5: reset in the middle of a frame
    for (int k = 0; k < 3; k++) begin
      data_in_valid = 1'b1; data_in = 8'(8'h55 + k); data_in_last = 1'b0;
      tick();
    end
    data_in_valid = 1'b0; rst = 1'b1;
    #1;
    check("t5_rst_in_ready", {31'd0, data_in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("t5_valid", {31'd0, data_out_valid}, 32'd0);
    check("t5_data", data_out, 32'd0);
    check("t5_keep", {28'd0, data_out_keep}, 32'd0);
    check("t5_in_ready", {31'd0, data_in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      data_in_valid = 1'b1; data_in = 8'(8'h11 + k); data_in_last = (k == 3);
      tick();
    end
    data_in_valid = 1'b0; data_in_last = 1'b0;
    #1;
    check("t5_word", data_out, 32'h14131211);
    check("t5_keep_f", {28'd0, data_out_keep}, 32'hF);
    tick(); tick();

    // 6: continuous stream with a free-running consumer
    nacc = 0; got_done = 1'b0; rdy_drop = 1'b0; maxcnt = 0; flush_rdy = 1'b1;
    for (int c = 0; c < 40 && !got_done; c++) begin
      data_in_valid = (nacc < 12); data_in = 8'(8'h20 + nacc); data_in_last = (nacc == 11);
      #1;
      if (data_in_valid && !data_in_ready) rdy_drop = 1'b1;
      if (c == 12) flush_rdy = data_in_ready;
      if (data_in_valid && data_in_ready) nacc++;
      if (data_out_valid) pops.push_back(c);
      if (int'(dut.count_q) > maxcnt) maxcnt = int'(dut.count_q);
      tick();
      if (done_vector_packing) got_done = 1'b1;
    end
    data_in_valid = 1'b0; data_in_last = 1'b0;
    check("t6_done", {31'd0, got_done}, 32'd1);
    check("t6_no_ready_drop", {31'd0, rdy_drop}, 32'd0);
    check("t6_flush_ready", {31'd0, flush_rdy}, 32'd0);
    check("t6_max_count", 32'(maxcnt), 32'd1);
    check("t6_pop_count", 32'(pops.size()), 32'd3);
    if (pops.size() == 3) begin
      check("t6_first_pop", 32'(pops[0]), 32'd4);
      check("t6_gap1", 32'(pops[1] - pops[0]), 32'd4);
      check("t6_gap2", 32'(pops[2] - pops[1]), 32'd4);
    end
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
